// File: rtl/slave_port_if.sv
// Serial system-bus link between a master port and one slave port.
// master drives mwdata/mmode/mvalid; slave returns srdata/svalid.
interface slave_port_if;
  logic mwdata;
  logic mmode;
  logic mvalid;
  logic srdata;
  logic svalid;

  modport master (
    output mwdata,
    output mmode,
    output mvalid,
    input  srdata,
    input  svalid
  );

  modport slave (
    input  mwdata,
    input  mmode,
    input  mvalid,
    output srdata,
    output svalid
  );
endinterface

// File: rtl/slave_port.sv
// Slave-side serial bus endpoint: deserialises addr/wdata LSB first,
// does one memory access, serialises read data back.
// Ports: clk, rstn (sync, active-low), bus (slave modport),
// mem_* request/response to local memory, busy (not idle).
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_NUM  = CW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEMWR, MEMRD, SEND
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;

  // Shift in from the MSB end: after a full phase the first
  // (LSB) bit has landed at index 0.
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;

  assign addr_nx  = {bus.mwdata, addr_q[ADDR_WIDTH-1:1]};
  assign wdata_nx = {bus.mwdata, wdata_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    srdata_d    = srdata_q;
    svalid_d    = svalid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = 1'b0;
    mem_ren_d   = mem_ren_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mvalid) begin
          addr_d  = addr_nx;
          mode_d  = bus.mmode;
          cnt_d   = CW'(1);
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!bus.mvalid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          addr_d = addr_nx;
          if (cnt_q == A_LAST) begin
            cnt_d      = '0;
            mem_addr_d = addr_nx;
            state_d    = mode_q ? WDATA : MEMRD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WDATA: begin
        if (!bus.mvalid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          wdata_d = wdata_nx;
          if (cnt_q == D_LAST) begin
            cnt_d       = '0;
            mem_wdata_d = wdata_nx;
            mem_wen_d   = 1'b1;
            state_d     = MEMWR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MEMWR: begin
        state_d = IDLE;
      end
      MEMRD: begin
        // rvalid only counts once the request is visible outside
        if (mem_ren_q && mem_rvalid) begin
          mem_ren_d = 1'b0;
          srdata_d  = mem_rdata[0];
          svalid_d  = 1'b1;
          rdata_d   = mem_rdata >> 1;
          cnt_d     = CW'(1);
          state_d   = SEND;
        end else begin
          mem_ren_d = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == D_NUM) begin
          svalid_d = 1'b0;
          srdata_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          srdata_d = rdata_q[0];
          rdata_d  = rdata_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      srdata_q    <= 1'b0;
      svalid_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      srdata_q    <= srdata_d;
      svalid_q    <= svalid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
    end
  end

  assign bus.srdata = srdata_q;
  assign bus.svalid = svalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign mem_ren    = mem_ren_q;
  assign busy       = (state_q != IDLE);

endmodule
